// File: rtl/ether_pkg.sv
// Shared types and constants for the RMII transmit framer and its CRC engine.
package ether_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    PAYLOAD,
    PAD,
    FCS,
    IFG
  } state_t;

  localparam logic [1:0]  PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0]  SFD_LAST_DIBIT = 2'b11;

  localparam logic [31:0] CRC_POLY_REFL  = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT       = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE    = 32'hDEBB20E3;

endpackage

// File: rtl/ether_tx_crc32_dibit.sv
// Reflected CRC-32 engine consuming one dibit (LSb first) per valid cycle.
module crc32_dibit
  import ether_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        clear,
  input  logic        valid,
  input  logic [1:0]  dibit,
  output logic [31:0] crc
);

  logic [31:0] crc_reg;
  logic [31:0] crc_next;

  always_comb begin
    crc_next = crc_reg;
    for (int i = 0; i < 2; i++) begin
      if (crc_next[0] ^ dibit[i]) begin
        crc_next = (crc_next >> 1) ^ CRC_POLY_REFL;
      end else begin
        crc_next = crc_next >> 1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || clear) begin
      crc_reg <= CRC_INIT;
    end else if (valid) begin
      crc_reg <= crc_next;
    end
  end

  assign crc = crc_reg;

endmodule

// File: rtl/ether_tx.sv
// RMII transmit framer: preamble/SFD, payload, zero pad, FCS and inter-frame gap,
// one registered dibit per clock.
module ether_tx
  import ether_pkg::*;
#(
  parameter int PREAMBLE_BYTES  = 7,
  parameter int MIN_FRAME_BYTES = 60,
  parameter int IFG_DIBITS      = 48
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       axiiv,
  input  logic [7:0] axiid,
  input  logic       axiil,
  output logic       axiir,
  output logic       eth_txen,
  output logic [1:0] eth_txd,
  output logic       busy_out,
  output logic       done_out,
  output logic       err_out
);

  localparam logic [15:0] PRE_LAST  = 16'(4 * PREAMBLE_BYTES + 3);
  localparam logic [15:0] SFD_POS   = 16'(4 * PREAMBLE_BYTES + 2);
  localparam logic [15:0] IFG_LAST  = 16'(IFG_DIBITS - 1);
  localparam logic [10:0] MIN_BYTES = 11'(MIN_FRAME_BYTES);

  // State and counters describe the dibit currently on the wire; the
  // combinational block picks the dibit that will be registered next.
  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [7:0]  byte_reg, byte_next;
  logic        last_reg, last_next;
  logic [10:0] byte_cnt_reg, byte_cnt_next;
  logic [1:0]  txd_reg, txd_next;
  logic        txen_reg, txen_next;
  logic        done_reg, done_next;
  logic        err_reg, err_next;

  logic        ready;
  logic        accept;
  logic        crc_clear;
  logic        crc_valid;
  logic [31:0] crc_value;
  logic [1:0]  next_sel;
  logic [3:0]  fcs_sel;
  logic [1:0]  byte_dibit;
  logic [1:0]  fcs_dibit;
  logic [10:0] byte_cnt_inc;

  crc32_dibit u_crc (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clear  (crc_clear),
    .valid  (crc_valid),
    .dibit  (txd_next),
    .crc    (crc_value)
  );

  always_comb begin
    ready = 1'b0;
    if (!rst_in) begin
      case (state_reg)
        IDLE:    ready = 1'b1;
        PAYLOAD: ready = (cnt_reg[1:0] == 2'd3) && !last_reg;
        default: ready = 1'b0;
      endcase
    end
  end

  assign axiir        = ready;
  assign accept       = ready && axiiv;
  assign next_sel     = cnt_reg[1:0] + 2'd1;
  assign fcs_sel      = cnt_reg[3:0] + 4'd1;
  assign byte_dibit   = byte_reg[{next_sel, 1'b0} +: 2];
  assign fcs_dibit    = ~crc_value[{fcs_sel, 1'b0} +: 2];
  assign byte_cnt_inc = (byte_cnt_reg == 11'h7FF) ? byte_cnt_reg : byte_cnt_reg + 11'd1;

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg + 16'd1;
    byte_next     = byte_reg;
    last_next     = last_reg;
    byte_cnt_next = byte_cnt_reg;
    txd_next      = 2'b00;
    txen_next     = 1'b0;
    done_next     = 1'b0;
    err_next      = 1'b0;
    crc_clear     = 1'b0;
    crc_valid     = 1'b0;

    case (state_reg)
      IDLE: begin
        crc_clear = 1'b1;
        cnt_next  = 16'd0;
        if (accept) begin
          state_next    = PREAMBLE;
          byte_next     = axiid;
          last_next     = axiil;
          byte_cnt_next = 11'd1;
          txd_next      = PREAMBLE_DIBIT;
          txen_next     = 1'b1;
        end
      end

      PREAMBLE: begin
        txen_next = 1'b1;
        if (cnt_reg == PRE_LAST) begin
          state_next = PAYLOAD;
          cnt_next   = 16'd0;
          txd_next   = byte_reg[1:0];
          crc_valid  = 1'b1;
        end else begin
          txd_next = (cnt_reg == SFD_POS) ? SFD_LAST_DIBIT : PREAMBLE_DIBIT;
        end
      end

      PAYLOAD: begin
        txen_next = 1'b1;
        if (cnt_reg[1:0] != 2'd3) begin
          txd_next  = byte_dibit;
          crc_valid = 1'b1;
        end else if (last_reg) begin
          cnt_next = 16'd0;
          if (byte_cnt_reg < MIN_BYTES) begin
            state_next    = PAD;
            byte_cnt_next = byte_cnt_inc;
            crc_valid     = 1'b1;
          end else begin
            state_next = FCS;
            txd_next   = ~crc_value[1:0];
          end
        end else if (accept) begin
          byte_next     = axiid;
          last_next     = axiil;
          byte_cnt_next = byte_cnt_inc;
          cnt_next      = 16'd0;
          txd_next      = axiid[1:0];
          crc_valid     = 1'b1;
        end else begin
          // Source starved: drop txen immediately and still enforce the gap.
          state_next = IFG;
          cnt_next   = 16'd0;
          txen_next  = 1'b0;
          err_next   = 1'b1;
        end
      end

      PAD: begin
        txen_next = 1'b1;
        if (cnt_reg[1:0] != 2'd3) begin
          crc_valid = 1'b1;
        end else begin
          cnt_next = 16'd0;
          if (byte_cnt_reg < MIN_BYTES) begin
            byte_cnt_next = byte_cnt_inc;
            crc_valid     = 1'b1;
          end else begin
            state_next = FCS;
            txd_next   = ~crc_value[1:0];
          end
        end
      end

      FCS: begin
        txen_next = 1'b1;
        txd_next  = fcs_dibit;
        // The 16th dibit is loaded here; the gap counts from the cycle it is on the wire.
        if (cnt_reg[3:0] == 4'd14) begin
          state_next = IFG;
          cnt_next   = 16'd0;
          done_next  = 1'b1;
        end
      end

      IFG: begin
        if (cnt_reg == IFG_LAST) begin
          state_next = IDLE;
          cnt_next   = 16'd0;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg    <= IDLE;
      cnt_reg      <= 16'd0;
      byte_reg     <= 8'd0;
      last_reg     <= 1'b0;
      byte_cnt_reg <= 11'd0;
      txd_reg      <= 2'b00;
      txen_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      byte_reg     <= byte_next;
      last_reg     <= last_next;
      byte_cnt_reg <= byte_cnt_next;
      txd_reg      <= txd_next;
      txen_reg     <= txen_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
    end
  end

  assign eth_txd  = txd_reg;
  assign eth_txen = txen_reg;
  assign done_out = done_reg;
  assign err_out  = err_reg;
  assign busy_out = (state_reg != IDLE);

endmodule

// File: tb/tb_ether_tx.sv
// Directed bench for ether_tx: expected wire dibits and frame lengths are queued
// as each frame is driven and consumed by a monitor as the framer transmits.
module tb_ether_tx;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       axiiv;
  logic [7:0] axiid;
  logic       axiil;
  logic       axiir;
  logic       eth_txen;
  logic [1:0] eth_txd;
  logic       busy_out;
  logic       done_out;
  logic       err_out;

  always #5 clk_in = ~clk_in;

  ether_tx dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .axiiv    (axiiv),
    .axiid    (axiid),
    .axiil    (axiil),
    .axiir    (axiir),
    .eth_txen (eth_txen),
    .eth_txd  (eth_txd),
    .busy_out (busy_out),
    .done_out (done_out),
    .err_out  (err_out)
  );

  int total = 0;
  int bad   = 0;

  logic [1:0] exp_q[$];
  int         len_q[$];

  int          frame_idx  = 0;
  int          last_len   = 0;
  int          low_run    = 0;
  int          last_gap   = 0;
  int          done_cnt   = 0;
  int          err_cnt    = 0;
  int          rdy_pulses = 0;
  logic [31:0] crc_run    = 32'hFFFFFFFF;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int k = 0; k < 2; k++) r = (r[0] ^ d[k]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Queue the wire image of a frame; full=0 queues only preamble and the given bytes.
  task automatic push_frame(input logic [7:0] data[$], input bit full);
    logic [31:0] c;
    logic [7:0]  b;
    int          n;
    for (int i = 0; i < 31; i++) exp_q.push_back(2'b01);
    exp_q.push_back(2'b11);
    n = data.size();
    if (full && n < 60) n = 60;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      b = (i < data.size()) ? data[i] : 8'h00;
      c = crc_byte(c, b);
      for (int k = 0; k < 4; k++) exp_q.push_back(b[2*k +: 2]);
    end
    if (full) begin
      c = ~c;
      for (int k = 0; k < 16; k++) exp_q.push_back(c[2*k +: 2]);
      len_q.push_back(32 + 4 * n + 16);
    end
  endtask

  // Call at a falling edge; words are {last, data}. stop_at withholds that byte.
  task automatic send(input logic [8:0] words[$], input int stop_at, output bit underrun);
    int i;
    int guard;
    i = 0;
    guard = 0;
    underrun = 1'b0;
    while (i < words.size() && guard < 4000) begin
      axiiv = (i != stop_at);
      axiid = words[i][7:0];
      axiil = words[i][8];
      #1;
      if (axiir && axiiv) begin
        i++;
      end else if (axiir && !axiiv) begin
        underrun = 1'b1;
        break;
      end
      guard++;
      @(negedge clk_in);
    end
    check("send_progress", 32'((i == words.size()) || underrun), 32'd1);
    if (!underrun) begin
      axiiv = 1'b0;
      axiil = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((busy_out || eth_txen) && g < 3000) begin
      @(negedge clk_in);
      g++;
    end
    check("idle_timeout", 32'(g < 3000), 32'd1);
  endtask

  function automatic void add_frame(ref logic [8:0] w[$], input logic [7:0] d[$]);
    for (int i = 0; i < d.size(); i++) w.push_back({(i == d.size() - 1), d[i]});
  endfunction

  always begin
    @(posedge clk_in);
    #1;
    if (axiir && busy_out) rdy_pulses++;
    if (err_out) err_cnt++;
    if (eth_txen) begin
      if (frame_idx == 0) begin
        last_gap = low_run;
        crc_run  = 32'hFFFFFFFF;
      end
      frame_idx++;
      low_run = 0;
      if (frame_idx > 32) crc_run = crc_dibit(crc_run, eth_txd);
      if (exp_q.size() == 0) check("extra_dibit", 32'(frame_idx), 32'd0);
      else check("txd", {30'd0, eth_txd}, {30'd0, exp_q.pop_front()});
      if (done_out) begin
        done_cnt++;
        if (len_q.size() == 0) check("done_unexpected", 32'(frame_idx), 32'd0);
        else check("done_pos", 32'(frame_idx), 32'(len_q.pop_front()));
        check("residue", crc_run, 32'hDEBB20E3);
      end
    end else begin
      if (frame_idx != 0) begin
        last_len  = frame_idx;
        frame_idx = 0;
      end
      low_run++;
      check("txd_idle", {30'd0, eth_txd}, 32'd0);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d[$];
    logic [7:0] d2[$];
    logic [8:0] w[$];
    bit         u;
    int         base_done, base_err, base_rdy, g;

    rst_in = 1'b1;
    axiiv  = 1'b0;
    axiid  = 8'h00;
    axiil  = 1'b0;
    repeat (2) @(negedge clk_in);
    check("rst_txen", 32'(eth_txen), 32'd0);
    check("rst_txd", 32'(eth_txd), 32'd0);
    check("rst_axiir", 32'(axiir), 32'd0);
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_done", 32'(done_out), 32'd0);
    check("rst_err", 32'(err_out), 32'd0);
    rst_in = 1'b0;
    @(negedge clk_in);
    check("ready_after_reset", 32'(axiir), 32'd1);

    // Short frame: padded to minimum size.
    d = '{8'hBF, 8'h7B, 8'hBE, 8'hFB};
    w.delete();
    add_frame(w, d);
    base_done = done_cnt;
    push_frame(d, 1'b1);
    send(w, -1, u);
    wait_idle();
    $display("frame short: len=%0d done=%0d", last_len, done_cnt - base_done);
    check("short_len", 32'(last_len), 32'd288);
    check("short_done", 32'(done_cnt - base_done), 32'd1);
    check("short_drain", 32'(exp_q.size()), 32'd0);

    // Minimum-size frame: no padding.
    d = '{8'h96, 8'h69, 8'hA5, 8'h09, 8'hA8, 8'h62,
          8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h01, 8'h01};
    for (int i = 0; i < 50; i++) d.push_back(8'(i * 7 + 3));
    w.delete();
    add_frame(w, d);
    base_done = done_cnt;
    base_rdy  = rdy_pulses;
    push_frame(d, 1'b1);
    send(w, -1, u);
    wait_idle();
    $display("frame 64B: len=%0d ready_pulses=%0d", last_len, rdy_pulses - base_rdy);
    check("min_len", 32'(last_len), 32'd304);
    check("min_ready_pulses", 32'(rdy_pulses - base_rdy), 32'd63);
    check("min_done", 32'(done_cnt - base_done), 32'd1);

    // Back-to-back with axiiv held high.
    d.delete();
    for (int i = 0; i < 5; i++) d.push_back(8'($urandom_range(0, 255)));
    d2.delete();
    for (int i = 0; i < 62; i++) d2.push_back(8'($urandom_range(0, 255)));
    w.delete();
    add_frame(w, d);
    add_frame(w, d2);
    base_done = done_cnt;
    push_frame(d, 1'b1);
    push_frame(d2, 1'b1);
    send(w, -1, u);
    wait_idle();
    $display("back-to-back: gap=%0d len2=%0d", last_gap, last_len);
    check("b2b_gap", 32'(last_gap), 32'd48);
    check("b2b_len2", 32'(last_len), 32'd296);
    check("b2b_done", 32'(done_cnt - base_done), 32'd2);
    check("b2b_drain", 32'(exp_q.size()), 32'd0);

    // Underrun on the 10th byte.
    d.delete();
    for (int i = 0; i < 20; i++) d.push_back(8'(8'hA0 + i));
    w.delete();
    add_frame(w, d);
    d2.delete();
    for (int i = 0; i < 9; i++) d2.push_back(d[i]);
    base_done = done_cnt;
    base_err  = err_cnt;
    push_frame(d2, 1'b0);
    send(w, 9, u);
    check("underrun_seen", 32'(u), 32'd1);
    @(negedge clk_in);
    check("underrun_txen", 32'(eth_txen), 32'd0);
    check("underrun_err", 32'(err_out), 32'd1);
    g = 0;
    while (!axiir && g < 200) begin
      g++;
      @(negedge clk_in);
    end
    $display("underrun: ifg=%0d err=%0d", g, err_cnt - base_err);
    check("underrun_ifg", 32'(g), 32'd48);
    check("underrun_err_cnt", 32'(err_cnt - base_err), 32'd1);
    check("underrun_no_done", 32'(done_cnt - base_done), 32'd0);
    check("underrun_drain", 32'(exp_q.size()), 32'd0);

    // Reset while the 5th FCS dibit is on the wire.
    d = '{8'h12, 8'h34, 8'h56, 8'h78};
    w.delete();
    add_frame(w, d);
    push_frame(d, 1'b1);
    send(w, -1, u);
    g = 0;
    while (frame_idx != 277 && g < 1000) begin
      @(negedge clk_in);
      g++;
    end
    check("fcs5_reached", 32'(frame_idx), 32'd277);
    rst_in = 1'b1;
    @(negedge clk_in);
    check("midrst_txen", 32'(eth_txen), 32'd0);
    check("midrst_axiir", 32'(axiir), 32'd0);
    check("midrst_busy", 32'(busy_out), 32'd0);
    exp_q.delete();
    len_q.delete();
    rst_in = 1'b0;
    #1;
    check("midrst_ready", 32'(axiir), 32'd1);
    d = '{8'hC3, 8'h5A, 8'hE1};
    w.delete();
    add_frame(w, d);
    base_done = done_cnt;
    push_frame(d, 1'b1);
    send(w, -1, u);
    wait_idle();
    $display("after reset: len=%0d done=%0d", last_len, done_cnt - base_done);
    check("post_rst_len", 32'(last_len), 32'd288);
    check("post_rst_done", 32'(done_cnt - base_done), 32'd1);
    check("post_rst_drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
